// File: rtl/floating_pkg.sv
// Shared definitions for the binary32 adder and related float blocks.
// Optional debug port of floating_add: FLOAT_ADD_DEBUG_EN.
package floating_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Adder sequencer states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_ALIGN  = 3'd2,
        S_ADD    = 3'd3,
        S_NORM   = 3'd4,
        S_PACK   = 3'd5
    } state_t;

endpackage

// File: rtl/floating_unpack.sv
// Combinational binary32 field split with zero / Inf / NaN classification.
// Denormals report as zero so callers can flush them directly.
module floating_unpack
    import floating_pkg::*;
(
    input  logic [31:0]       i_f,
    output logic              o_sign,
    output logic [EXP_W-1:0]  o_exp,
    output logic [FRAC_W-1:0] o_frac,
    output logic              o_zero,
    output logic              o_special,
    output logic              o_inf
);

    logic [EXP_W-1:0] w_exp_max;

    assign w_exp_max = EXP_W'(EXP_MAX);

    assign o_sign    = i_f[31];
    assign o_exp     = i_f[30:23];
    assign o_frac    = i_f[22:0];
    assign o_zero    = (o_exp == '0);
    assign o_special = (o_exp == w_exp_max);
    assign o_inf     = o_special && (o_frac == '0);

endmodule

// File: rtl/floating_add.sv
// Sequential binary32 adder: unpack, align, add, iterative normalize, pack.
// Truncating, flush-to-zero. FLOAT_ADD_DEBUG_EN adds the debug port.
module floating_add
    import floating_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] out,
    output logic        done,
    output logic        busy
`ifdef FLOAT_ADD_DEBUG_EN
    ,
    output logic [31:0] debug
`endif
);

    state_t      r_state;
    logic [31:0] r_a;
    logic [31:0] r_b;

    logic        r_sx;
    logic        r_sy;
    logic [7:0]  r_ex;
    logic [7:0]  r_ey;
    logic [23:0] r_mx;
    logic [23:0] r_my;

    logic        r_spec;
    logic [31:0] r_spec_res;

    logic        r_sign;
    logic [7:0]  r_exp;
    logic [24:0] r_m;

    logic [31:0] r_out;
    logic        r_done;

    logic        w_sa;
    logic        w_sb;
    logic [7:0]  w_ea;
    logic [7:0]  w_eb;
    logic [22:0] w_fa;
    logic [22:0] w_fb;
    logic        w_za;
    logic        w_zb;
    logic        w_spa;
    logic        w_spb;
    logic        w_infa;
    logic        w_infb;

    logic [31:0] w_spec_res;
    logic        w_x_is_a;
    logic [7:0]  w_d;
    logic [23:0] w_m_small;
    logic [23:0] w_my_sh;
    logic [24:0] w_sum;

    floating_unpack u_unpack_a (
        .i_f       (r_a),
        .o_sign    (w_sa),
        .o_exp     (w_ea),
        .o_frac    (w_fa),
        .o_zero    (w_za),
        .o_special (w_spa),
        .o_inf     (w_infa)
    );

    floating_unpack u_unpack_b (
        .i_f       (r_b),
        .o_sign    (w_sb),
        .o_exp     (w_eb),
        .o_frac    (w_fb),
        .o_zero    (w_zb),
        .o_special (w_spb),
        .o_inf     (w_infb)
    );

    // Inf - Inf is the only invalid sum; otherwise A's NaN/Inf wins over B's.
    always_comb begin
        w_spec_res = r_b;
        if (w_infa && w_infb && (w_sa != w_sb)) begin
            w_spec_res = QNAN;
        end else if (w_spa) begin
            w_spec_res = r_a;
        end
    end

    // Magnitude compare (exponent, then mantissa) and truncating alignment.
    always_comb begin
        w_x_is_a  = ({r_ex, r_mx} >= {r_ey, r_my});
        w_d       = w_x_is_a ? (r_ex - r_ey) : (r_ey - r_ex);
        w_m_small = w_x_is_a ? r_my : r_mx;
        w_my_sh   = (w_d >= 8'd25) ? 24'd0 : (w_m_small >> w_d);
    end

    // X holds the larger magnitude, so the difference never goes negative.
    always_comb begin
        if (r_sx == r_sy) begin
            w_sum = {1'b0, r_mx} + {1'b0, r_my};
        end else begin
            w_sum = {1'b0, r_mx} - {1'b0, r_my};
        end
    end

    // Operation sequencer and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_sx       <= 1'b0;
            r_sy       <= 1'b0;
            r_ex       <= '0;
            r_ey       <= '0;
            r_mx       <= '0;
            r_my       <= '0;
            r_spec     <= 1'b0;
            r_spec_res <= '0;
            r_sign     <= 1'b0;
            r_exp      <= '0;
            r_m        <= '0;
            r_out      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    r_sx       <= w_sa;
                    r_sy       <= w_sb;
                    r_ex       <= w_ea;
                    r_ey       <= w_eb;
                    r_mx       <= w_za ? 24'd0 : {1'b1, w_fa};
                    r_my       <= w_zb ? 24'd0 : {1'b1, w_fb};
                    r_spec     <= w_spa || w_spb;
                    r_spec_res <= w_spec_res;
                    r_state    <= S_ALIGN;
                end
                S_ALIGN: begin
                    if (r_spec) begin
                        r_sign  <= r_spec_res[31];
                        r_exp   <= r_spec_res[30:23];
                        r_m     <= {2'b00, r_spec_res[22:0]};
                        r_state <= S_PACK;
                    end else begin
                        r_sx    <= w_x_is_a ? r_sx : r_sy;
                        r_sy    <= w_x_is_a ? r_sy : r_sx;
                        r_ex    <= w_x_is_a ? r_ex : r_ey;
                        r_ey    <= w_x_is_a ? r_ey : r_ex;
                        r_mx    <= w_x_is_a ? r_mx : r_my;
                        r_my    <= w_my_sh;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    if (w_sum == '0) begin
                        r_sign  <= 1'b0;
                        r_exp   <= '0;
                        r_m     <= '0;
                        r_state <= S_PACK;
                    end else begin
                        r_sign  <= r_sx;
                        r_exp   <= r_ex;
                        r_m     <= w_sum;
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (r_m[24]) begin
                        if (r_exp == 8'd254) begin
                            r_exp   <= 8'd255;
                            r_m     <= '0;
                            r_state <= S_PACK;
                        end else begin
                            r_exp <= r_exp + 8'd1;
                            r_m   <= r_m >> 1;
                        end
                    end else if (!r_m[23]) begin
                        if (r_exp == 8'd1) begin
                            r_exp   <= '0;
                            r_m     <= '0;
                            r_state <= S_PACK;
                        end else begin
                            r_exp <= r_exp - 8'd1;
                            r_m   <= r_m << 1;
                        end
                    end else begin
                        r_state <= S_PACK;
                    end
                end
                S_PACK: begin
                    r_out   <= {r_sign, r_exp, r_m[22:0]};
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out  = r_out;
    assign done = r_done;
    assign busy = (r_state != S_IDLE);

`ifdef FLOAT_ADD_DEBUG_EN
    assign debug = {7'b0, r_m};
`endif

endmodule

// File: tb/tb_floating_add.sv
// Randomized scoreboard bench for floating_add.
// Reference model works on whole-number mantissas and leading-one position.
module tb_floating_add;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic        done;
    logic        busy;
`ifdef FLOAT_ADD_DEBUG_EN
    logic [31:0] debug;
`endif

    floating_add dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .out   (out),
        .done  (done),
`ifdef FLOAT_ADD_DEBUG_EN
        .debug (debug),
`endif
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          e0;
    } item_t;

    item_t       sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] last_out = '0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, got, exp);
    endtask

    // Behavioural reference: exact integer sum of truncated operands,
    // normalized by locating the leading one.
    function automatic void ref_add(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] r, output int lat);
        int     ex, ey, mx, my, d, sum, p, sh, t;
        bit     sx, sy, bt;
        longint kx, ky;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        sx = x[31];
        sy = y[31];
        if (ex == 255 || ey == 255) begin
            lat = 3;
            if (ex == 255 && ey == 255 && x[22:0] == 0 && y[22:0] == 0 && sx != sy)
                r = 32'h7FC0_0000;
            else if (ex == 255)
                r = x;
            else
                r = y;
            return;
        end
        mx = (ex == 0) ? 0 : ((1 << 23) + int'(x[22:0]));
        my = (ey == 0) ? 0 : ((1 << 23) + int'(y[22:0]));
        kx = longint'(ex) * 64'd16777216 + longint'(mx);
        ky = longint'(ey) * 64'd16777216 + longint'(my);
        if (ky > kx) begin
            t = ex; ex = ey; ey = t;
            t = mx; mx = my; my = t;
            bt = sx; sx = sy; sy = bt;
        end
        d = ex - ey;
        my = (d >= 25) ? 0 : (my >> d);
        sum = (sx == sy) ? (mx + my) : (mx - my);
        if (sum == 0) begin
            r = 32'h0;
            lat = 4;
            return;
        end
        p = 0;
        for (int i = 0; i < 25; i++) if (((sum >> i) & 1) == 1) p = i;
        if (p == 24) begin
            if (ex + 1 >= 255) begin
                r = {sx, 8'hFF, 23'd0};
                lat = 5;
            end else begin
                r = {sx, 8'(ex + 1), 23'(sum >> 1)};
                lat = 6;
            end
        end else begin
            sh = 23 - p;
            if (sh >= ex) begin
                r = {sx, 31'd0};
                lat = 4 + ex;
            end else begin
                r = {sx, 8'(ex - sh), 23'(sum << sh)};
                lat = 5 + sh;
            end
        end
    endfunction

    task automatic issue(input logic [31:0] x, input logic [31:0] y, output int e0);
        int          n;
        logic [31:0] r;
        int          l;
        item_t       it;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_chk++;
            $display("FAIL busy_timeout: got busy %b want 0", busy);
        end
        ref_add(x, y, r, l);
        e0 = cyc + 1;
        it.res = r;
        it.lat = l;
        it.e0 = e0;
        sb.push_back(it);
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: pops the scoreboard on each done, checks hold otherwise.
    always @(posedge clk) begin
        item_t it;
        #1;
        if (reset) begin
            last_out = '0;
        end else if (done) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done: got out %h want no done", out);
            end else begin
                it = sb.pop_front();
                check("result", out, it.res);
                check("latency", 32'(cyc - it.e0), 32'(it.lat));
                check("busy_in_done", {31'd0, busy}, 32'd0);
                last_out = out;
            end
        end else begin
            check("out_hold", out, last_out);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          e1, e2, n;
        logic [31:0] r;
        int          l1;
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        check("reset_out", out, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(32'h3F80_0000, 32'h3F80_0000, e1);
        issue(32'h3FC0_0000, 32'hBFA0_0000, e1);
        issue(32'h3F80_0000, 32'hBF80_0000, e1);
        issue(32'h7F80_0000, 32'hFF80_0000, e1);
        issue(32'h4B80_0000, 32'h3F80_0000, e1);

        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        a = 32'h3F80_0000;
        b = 32'h3F80_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("align_state_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_out", out, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        repeat (8) @(negedge clk);

        ref_add(32'h4040_0000, 32'h3F00_0000, r, l1);
        issue(32'h4040_0000, 32'h3F00_0000, e1);
        issue(32'hC120_0000, 32'h4110_0000, e2);
        check("no_gap", 32'(e2 - e1), 32'(l1 + 1));

        for (int i = 0; i < 200; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            int          ea;
            int          eb;
            int          kind;
            int          e;
            ea = $urandom_range(1, 254);
            eb = ea + $urandom_range(0, 6) - 3;
            if (eb < 1) eb = 1;
            if (eb > 254) eb = 254;
            kind = $urandom_range(0, 9);
            x = {1'($urandom), 8'(ea), 23'($urandom)};
            y = {1'($urandom), 8'(eb), 23'($urandom)};
            case (kind)
                0: y = x ^ 32'h8000_0000 ^ 32'($urandom_range(0, 3));
                1: y[30:23] = 8'($urandom_range(0, 254));
                2: x[30:23] = 8'h00;
                3: begin
                    y[30:23] = 8'hFF;
                    if ($urandom_range(0, 1) == 1) y[22:0] = '0;
                end
                4: begin
                    x[30:0] = {8'hFF, 23'd0};
                    y[30:0] = {8'hFF, 23'd0};
                end
                5: begin
                    x[30:23] = 8'd254;
                    y[31:23] = {x[31], 8'd254};
                end
                6: begin
                    x[30:23] = 8'($urandom_range(1, 3));
                    y = x ^ 32'h8000_0000 ^ 32'($urandom_range(1, 1 << 20));
                end
                default: ;
            endcase
            issue(x, y, e);
        end

        n = 0;
        while (sb.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/floating_add.md
# floating_add

Sequential single-precision (IEEE-754 binary32) adder sitting directly downstream of the integer-to-float converter in the Phaethon floating-point path; it consumes packed floats (e.g. converted integers) and produces their sum. Multi-cycle FSM: unpack, align, add, iterative normalize, pack. Truncation rounding and flush-to-zero, matching the converter's arithmetic conventions.

## Interface
- No parameters; binary32 only.
- Reset: one clock; reset is synchronous and active-high.
- `clk  in  1  clock`
- `reset  in  1  synchronous active-high reset`
- `start  in  1  request; sampled only when busy=0`
- `a  in  32  operand A, captured on accepted start`
- `b  in  32  operand B, captured on accepted start`
- `out  out  32  result; updated only with done, held otherwise`
- `done  out  1  one-cycle pulse, out valid`
- `busy  out  1  high while state != IDLE`
- `debug  out  32  only with FLOAT_ADD_DEBUG_EN (see Configuration)`

## Operation
- States: IDLE, UNPACK, ALIGN, ADD, NORM, PACK.
- IDLE: start=1 → capture a,b → UNPACK. start while busy is ignored.
- UNPACK:
  - exp=0 → operand is zero; mantissa forced to 0, denormals flushed.
  - Else mantissa = {1, frac}, 24 bits.
  - Either exp=255:
    - Inf + opposite-sign Inf → 0x7FC00000.
    - Else NaN/Inf operand returned unchanged; a has priority.
    - Go to PACK.
- ALIGN:
  - Order operands so X has the larger magnitude (exp first, then mantissa).
  - d = ex−ey. d≥25 → my=0; else my = my>>d, truncated.
- ADD:
  - Same sign: m = mx+my, 25 bits.
  - Opposite signs: m = mx−my, never negative.
  - Sign is sx.
  - m=0 → result 0x00000000 (+0) → PACK.
- NORM, one action per cycle:
  - m[24]=1 → m>>1, exp+1.
  - Else m[23]=0 → m<<1, exp−1.
  - Else → PACK.
  - exp reaching 255 → ±Inf (frac 0).
  - exp reaching 0 → signed zero; exit immediately.
- PACK: out = {sign, exp[7:0], m[22:0]}; done=1; → IDLE.

## Timing
- Reset: out=0, done=0, busy=0, state=IDLE, debug=0.
- Reset mid-operation aborts the operation: no done, out not updated.
- start accepted at edge E0 → busy=1 from E0.
- Latency, done high after edge:
  - Normal path: E5+k, k = NORM shift cycles (0..23; at most 1 for right shift).
  - Special (NaN/Inf): E3.
  - Zero sum: E4.
- done lasts exactly one cycle, with busy=0 in that same cycle.
- start asserted during the done cycle is accepted (back-to-back throughput).
- out is stable between done pulses.

## Configuration
- FLOAT_ADD_DEBUG_EN defined:
  - `debug` port exists.
  - Updated each cycle with {7'b0, m[24:0]}, the working mantissa.
- Undefined: port and its logic absent; functional behaviour identical.

## Structure
- Shared package `floating_pkg`:
  - State enum.
  - EXP_W=8, FRAC_W=23, EXP_BIAS=127, EXP_MAX=255.
  - QNAN=32'h7FC00000.
- One natural sub-module `floating_unpack`: combinational field split plus zero/special classification. Reusable by future float blocks.

## Test plan
- 0x3F800000 + 0x3F800000 (1+1) → out=0x40000000, done at E6 (one right-shift NORM cycle).
- 0x3FC00000 + 0xBFA00000 (1.5−1.25) → out=0x3E800000, k=2, done at E7.
- 0x3F800000 + 0xBF800000 → out=0x00000000 at E4.
- 0x7F800000 + 0xFF800000 → 0x7FC00000 at E3.
- 0x4B800000 + 0x3F800000 (d=24, truncated) → 0x4B800000.
- Reset during ALIGN → no done, out=0. Then start asserted during a done cycle → second result correct with no idle gap.
